// File: rtl/hwag_pkg.sv
// Shared types and constants for the hardware angle generator sync sequencer.
package hwag_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_SEARCH = 3'd2,
        ST_SYNC   = 3'd3,
        ST_STALL  = 3'd4
    } state_t;

    typedef struct packed {
        logic sync_ok;
        logic sync_loss;
        logic stall;
        logic gap;
        logic tooth;
    } pulse_t;

    // Edges needed to populate the three-deep period capture history.
    localparam int FILL_DEPTH = 3;

endpackage

// File: rtl/hwag_tooth_cnt.sv
// Tooth index counter: clears, increments, and wraps to 0 once the index
// has reached or passed the gap tooth number.
module hwag_tooth_cnt #(
    parameter int TW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    input  logic [TW-1:0] thnb,
    output logic [TW-1:0] cnt,
    output logic          at_gap
);

    // A >= test (not ==) makes a thnb lowered below cnt wrap on the next edge.
    assign at_gap = (cnt >= thnb);

    // NOTE: state registers use non-blocking assignments so every flop in the
    // design samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= at_gap ? '0 : cnt + TW'(1);
        end
    end

endmodule

// File: rtl/hwag_sync_ctrl.sv
// Synchronisation sequencer: FILL/SEARCH/SYNC/STALL control, loss-of-sync
// and stall detection, and registered single-cycle event pulses.
module hwag_sync_ctrl
    import hwag_pkg::*;
#(
    parameter int TW = 8,
    parameter int EW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cape,
    input  logic          vr_edge,
    input  logic          pcnt_ovf,
    input  logic          period_ok,
    input  logic          gap_found,
    input  logic          gap_run,
    input  logic [TW-1:0] thnb,
    input  logic [EW-1:0] err_lim,
    output logic          pcap_ena,
    output logic          sync,
    output logic [TW-1:0] tooth_cnt,
    output logic          gap_point,
    output logic [2:0]    state,
    output logic          sync_ok_if,
    output logic          sync_loss_if,
    output logic          stall_if,
    output logic          gap_if,
    output logic          tooth_if
);

    state_t        state_q, state_d;
    logic [1:0]    fill_q, fill_d;
    logic [EW-1:0] err_q, err_d;
    pulse_t        pulse_q, pulse_d;
    logic          tooth_clr, tooth_inc, at_gap;

    logic [EW-1:0] lim_eff;
    logic [EW:0]   err_next;
    logic          loss_hit;
    logic [EW-1:0] err_sat;

    hwag_tooth_cnt #(.TW(TW)) u_tooth (
        .clk    (clk),
        .rst    (rst),
        .clr    (tooth_clr),
        .inc    (tooth_inc),
        .thnb   (thnb),
        .cnt    (tooth_cnt),
        .at_gap (at_gap)
    );

    assign state     = state_q;
    assign sync      = (state_q == ST_SYNC);
    assign gap_point = sync & at_gap;
    // Capture history is frozen across the gap tooth.
    assign pcap_ena  = vr_edge & ((state_q == ST_FILL) | (state_q == ST_SEARCH) |
                                  (sync & ~gap_point));

    assign lim_eff  = (err_lim == '0) ? EW'(1) : err_lim;
    assign err_next = {1'b0, err_q} + {{EW{1'b0}}, 1'b1};
    assign loss_hit = (err_next >= {1'b0, lim_eff});
    assign err_sat  = (&err_q) ? err_q : err_q + EW'(1);

    assign sync_ok_if   = pulse_q.sync_ok;
    assign sync_loss_if = pulse_q.sync_loss;
    assign stall_if     = pulse_q.stall;
    assign gap_if       = pulse_q.gap;
    assign tooth_if     = pulse_q.tooth;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        fill_d    = fill_q;
        err_d     = err_q;
        pulse_d   = '0;
        tooth_clr = 1'b0;
        tooth_inc = 1'b0;

        if (!cape) begin
            state_d   = ST_IDLE;
            fill_d    = '0;
            err_d     = '0;
            tooth_clr = 1'b1;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_d = ST_FILL;
                    fill_d  = '0;
                end
                ST_FILL: begin
                    if (pcnt_ovf) begin
                        state_d       = ST_STALL;
                        pulse_d.stall = 1'b1;
                    end else if (vr_edge) begin
                        fill_d = fill_q + 2'd1;
                        if (fill_q == 2'(FILL_DEPTH - 1)) state_d = ST_SEARCH;
                    end
                end
                ST_SEARCH: begin
                    if (pcnt_ovf) begin
                        state_d       = ST_STALL;
                        pulse_d.stall = 1'b1;
                    end else if (vr_edge && period_ok && gap_found) begin
                        state_d         = ST_SYNC;
                        err_d           = '0;
                        tooth_clr       = 1'b1;
                        pulse_d.sync_ok = 1'b1;
                    end
                end
                ST_SYNC: begin
                    if (pcnt_ovf) begin
                        state_d           = ST_STALL;
                        pulse_d.stall     = 1'b1;
                        pulse_d.sync_loss = 1'b1;
                    end else if (vr_edge) begin
                        tooth_inc = 1'b1;
                        if (gap_run == at_gap) begin
                            if (at_gap) begin
                                pulse_d.gap = 1'b1;
                                err_d       = '0;
                            end else begin
                                pulse_d.tooth = 1'b1;
                            end
                        end else begin
                            err_d = err_sat;
                            if (loss_hit) begin
                                state_d           = ST_FILL;
                                fill_d            = '0;
                                pulse_d.sync_loss = 1'b1;
                            end
                        end
                    end
                end
                ST_STALL: begin
                    if (vr_edge) begin
                        state_d = ST_FILL;
                        fill_d  = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            fill_q  <= '0;
            err_q   <= '0;
            pulse_q <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
            pulse_q <= pulse_d;
        end
    end

endmodule

// File: tb/tb_hwag_sync_ctrl.sv
// Self-checking bench for hwag_sync_ctrl: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
module tb_hwag_sync_ctrl;

    localparam int TW = 8;
    localparam int EW = 4;

    logic          clk = 1'b0;
    logic          rst, cape, vr_edge, pcnt_ovf, period_ok, gap_found, gap_run;
    logic [TW-1:0] thnb;
    logic [EW-1:0] err_lim;
    logic          pcap_ena, sync, gap_point;
    logic [TW-1:0] tooth_cnt;
    logic [2:0]    state;
    logic          sync_ok_if, sync_loss_if, stall_if, gap_if, tooth_if;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    hwag_sync_ctrl #(.TW(TW), .EW(EW)) dut (
        .clk          (clk),
        .rst          (rst),
        .cape         (cape),
        .vr_edge      (vr_edge),
        .pcnt_ovf     (pcnt_ovf),
        .period_ok    (period_ok),
        .gap_found    (gap_found),
        .gap_run      (gap_run),
        .thnb         (thnb),
        .err_lim      (err_lim),
        .pcap_ena     (pcap_ena),
        .sync         (sync),
        .tooth_cnt    (tooth_cnt),
        .gap_point    (gap_point),
        .state        (state),
        .sync_ok_if   (sync_ok_if),
        .sync_loss_if (sync_loss_if),
        .stall_if     (stall_if),
        .gap_if       (gap_if),
        .tooth_if     (tooth_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: mode 0..4 = idle, fill, search, sync, stall.
    typedef struct {
        int mode;
        int fill;
        int err;
        int tooth;
        bit ok, loss, stall, gap, tth;
    } mdl_t;

    mdl_t m = '{default: 0};

    function automatic mdl_t step(input mdl_t c);
        mdl_t n;
        int   lim;
        bit   gp;
        n       = c;
        n.ok    = 0;
        n.loss  = 0;
        n.stall = 0;
        n.gap   = 0;
        n.tth   = 0;
        lim     = (err_lim == 0) ? 1 : int'(err_lim);
        gp      = (c.tooth >= int'(thnb));
        if (rst || !cape) begin
            n.mode = 0; n.fill = 0; n.err = 0; n.tooth = 0;
        end else if (c.mode == 0) begin
            n.mode = 1; n.fill = 0;
        end else if (pcnt_ovf && c.mode >= 1 && c.mode <= 3) begin
            n.stall = 1;
            n.loss  = (c.mode == 3);
            n.mode  = 4;
        end else if (vr_edge) begin
            if (c.mode == 1) begin
                n.fill = c.fill + 1;
                if (n.fill == 3) n.mode = 2;
            end else if (c.mode == 2) begin
                if (period_ok && gap_found) begin
                    n.mode = 3; n.tooth = 0; n.err = 0; n.ok = 1;
                end
            end else if (c.mode == 3) begin
                n.tooth = gp ? 0 : (c.tooth + 1) % 256;
                if (gp == gap_run) begin
                    if (gp) begin n.gap = 1; n.err = 0; end
                    else    n.tth = 1;
                end else if (c.err + 1 >= lim) begin
                    n.mode = 1; n.fill = 0; n.loss = 1;
                end else begin
                    n.err = (c.err < 15) ? c.err + 1 : 15;
                end
            end else if (c.mode == 4) begin
                n.mode = 1; n.fill = 0;
            end
        end
        return n;
    endfunction

    always @(posedge clk) m <= step(m);

    always @(negedge clk) begin
        if (cmp_en) begin
            automatic bit exp_gp = (m.mode == 3) && (m.tooth >= int'(thnb));
            check("state",     state,        m.mode);
            check("sync",      sync,         m.mode == 3);
            check("tooth_cnt", tooth_cnt,    m.tooth);
            check("gap_point", gap_point,    exp_gp);
            check("pcap_ena",  pcap_ena,     vr_edge && (m.mode == 1 || m.mode == 2 ||
                                                         (m.mode == 3 && !exp_gp)));
            check("sync_ok",   sync_ok_if,   m.ok);
            check("sync_loss", sync_loss_if, m.loss);
            check("stall",     stall_if,     m.stall);
            check("gap",       gap_if,       m.gap);
            check("tooth",     tooth_if,     m.tth);
        end
    end

    task automatic tick(input logic e, input logic o);
        vr_edge  = e;
        pcnt_ovf = o;
        @(posedge clk);
        #2;
        vr_edge  = 1'b0;
        pcnt_ovf = 1'b0;
    endtask

    task automatic tick_pcap(input logic exp);
        vr_edge = 1'b1;
        #1;
        check("pcap_on_edge", pcap_ena, exp);
        @(posedge clk);
        #2;
        vr_edge = 1'b0;
    endtask

    task automatic edges(input int n, input logic gr);
        gap_run = gr;
        repeat (n) tick(1'b1, 1'b0);
        gap_run = 1'b0;
    endtask

    // From FILL: three capture edges, then a qualifying sync edge.
    task automatic to_sync();
        period_ok = 1'b0; gap_found = 1'b0;
        edges(3, 1'b0);
        period_ok = 1'b1; gap_found = 1'b1;
        tick(1'b1, 1'b0);
        period_ok = 1'b0; gap_found = 1'b0;
    endtask

    initial begin
        int n_tooth;
        rst = 1'b1; cape = 1'b1; vr_edge = 1'b0; pcnt_ovf = 1'b0;
        period_ok = 1'b0; gap_found = 1'b0; gap_run = 1'b0;
        thnb = 8'd57; err_lim = 4'd3;
        @(posedge clk); #2;
        cmp_en = 1'b1;
        tick(1'b0, 1'b0);
        check("rst_state", state, 0);
        check("rst_tooth", tooth_cnt, 0);
        check("rst_pulses", {sync_ok_if, sync_loss_if, stall_if, gap_if, tooth_if}, 0);

        // Fill then search
        rst = 1'b0;
        tick(1'b0, 1'b0);
        check("idle_to_fill", state, 1);
        tick_pcap(1'b1);
        tick_pcap(1'b1);
        check("fill_hold", state, 1);
        tick_pcap(1'b1);
        check("fill_to_search", state, 2);
        check("search_nosync", sync, 0);

        // Acquire sync and run a full revolution
        period_ok = 1'b1; gap_found = 1'b1;
        tick(1'b1, 1'b0);
        period_ok = 1'b0; gap_found = 1'b0;
        check("sync_hi", sync, 1);
        check("sync_tooth0", tooth_cnt, 0);
        check("sync_ok_pulse", sync_ok_if, 1);
        tick(1'b0, 1'b0);
        check("sync_ok_single", sync_ok_if, 0);
        n_tooth = 0;
        for (int i = 0; i < 57; i++) begin
            tick(1'b1, 1'b0);
            n_tooth += int'(tooth_if);
        end
        check("tooth_pulses", n_tooth, 57);
        check("tooth_57", tooth_cnt, 57);
        check("model_tooth_57", m.tooth, 57);
        check("gap_point_57", gap_point, 1);
        gap_run = 1'b1;
        tick_pcap(1'b0);
        gap_run = 1'b0;
        check("gap_pulse", gap_if, 1);
        check("gap_wrap", tooth_cnt, 0);

        // Loss of sync after two mismatches
        err_lim = 4'd2;
        edges(10, 1'b0);
        edges(1, 1'b1);
        check("mis1_state", state, 3);
        check("mis1_tooth", tooth_cnt, 11);
        check("mis1_noloss", sync_loss_if, 0);
        edges(1, 1'b1);
        check("mis2_state", state, 1);
        check("model_mis2_state", m.mode, 1);
        check("mis2_loss", sync_loss_if, 1);

        // Stall out of sync
        to_sync();
        edges(5, 1'b0);
        tick(1'b1, 1'b1);
        check("stall_state", state, 4);
        check("stall_pulse", stall_if, 1);
        check("stall_loss", sync_loss_if, 1);
        check("stall_tooth_hold", tooth_cnt, 5);
        tick_pcap(1'b0);
        check("stall_to_fill", state, 1);

        // cape drop mid-sync
        to_sync();
        edges(30, 1'b0);
        check("pre_cape_tooth", tooth_cnt, 30);
        cape = 1'b0;
        tick(1'b1, 1'b0);
        check("cape_idle", state, 0);
        check("cape_tooth0", tooth_cnt, 0);
        check("cape_nopulse", {sync_ok_if, sync_loss_if, stall_if, gap_if, tooth_if}, 0);
        cape = 1'b1;
        tick(1'b0, 1'b0);
        check("cape_refill", state, 1);

        // Lowering thnb below the current tooth
        to_sync();
        edges(40, 1'b0);
        thnb = 8'd20;
        #1;
        check("thnb_low_gp", gap_point, 1);
        edges(1, 1'b1);
        check("thnb_low_gap", gap_if, 1);
        check("thnb_low_wrap", tooth_cnt, 0);

        // Randomized traffic against the model
        thnb = TW'($urandom_range(0, 12));
        for (int i = 0; i < 4000; i++) begin
            rst       = ($urandom_range(0, 499) == 0);
            cape      = ($urandom_range(0, 99) != 0);
            if ($urandom_range(0, 199) == 0) thnb = TW'($urandom_range(0, 12));
            if ($urandom_range(0, 99) == 0) err_lim = EW'($urandom_range(0, 3));
            period_ok = 1'($urandom_range(0, 1));
            gap_found = 1'($urandom_range(0, 1));
            gap_run   = ((m.mode == 3) && (m.tooth >= int'(thnb))) ^ ($urandom_range(0, 9) == 0);
            vr_edge   = ($urandom_range(0, 2) != 0);
            pcnt_ovf  = ($urandom_range(0, 59) == 0);
            @(posedge clk);
            #2;
        end

        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
